// File: rtl/tmr_cfg_regfile_if.sv
// AXI4-Lite config bus seen by one TMR replica's register file.
// Handshakes: a beat transfers on a rising edge where valid & ready are both high; a source
// holds valid and its payload stable until that edge, and valid never waits on ready.
interface tmr_cfg_regfile_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/tmr_cfg_regfile.sv
// Deterministic AXI4-Lite config register file for one TMR replica: reg 0 ID, reg 1 live
// status, regs 2..N-1 read/write control exported on cfg_regs with per-reg write strobes.
module tmr_cfg_regfile #(
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            C_S_AXI_ADDR_WIDTH = 32,
    parameter int                            NUM_REGS           = 8,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] ID_VALUE           = 32'h544D5230,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] RW_RESET           = '0
) (
    input  logic                                     axi_aclk,
    input  logic                                     axi_resetn,
    tmr_cfg_regfile_if.slave                         s00_axi,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            status_in,
    output logic [(NUM_REGS-2)*C_S_AXI_DATA_WIDTH-1:0] cfg_regs,
    output logic [NUM_REGS-1:0]                      cfg_wr_stb
);
    localparam int               DW      = C_S_AXI_DATA_WIDTH;
    localparam int               AW      = C_S_AXI_ADDR_WIDTH;
    localparam int               IDX_W   = AW - 2;
    localparam logic [IDX_W-1:0] NUM_IDX = IDX_W'(NUM_REGS);
    localparam logic [1:0]       OKAY    = 2'b00;
    localparam logic [1:0]       SLVERR  = 2'b10;

    logic                     r_aw_held;
    logic                     r_w_held;
    logic [AW-1:0]            r_awaddr;
    logic [DW-1:0]            r_wdata;
    logic                     r_bvalid;
    logic [1:0]               r_bresp;
    logic                     r_rvalid;
    logic [1:0]               r_rresp;
    logic [DW-1:0]            r_rdata;
    logic [(NUM_REGS-2)*DW-1:0] r_cfg;
    logic [NUM_REGS-1:0]      r_wr_stb;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_aw_av;
    logic                w_w_av;
    logic                w_b_free;
    logic                w_commit;
    logic [AW-1:0]       w_wr_addr;
    logic [DW-1:0]       w_wr_data;
    logic [IDX_W-1:0]    w_wr_idx;
    logic                w_wr_ok;
    logic [NUM_REGS-1:0] w_wr_hot;
    logic                w_arready;
    logic                w_ar_hs;
    logic [IDX_W-1:0]    w_rd_idx;
    logic [DW-1:0]       w_rd_data;
    logic [1:0]          w_rd_resp;
    logic                w_unused_addr_bits;

    assign s00_axi.awready = ~r_aw_held;
    assign s00_axi.wready  = ~r_w_held;
    assign s00_axi.bvalid  = r_bvalid;
    assign s00_axi.bresp   = r_bresp;
    assign s00_axi.arready = w_arready;
    assign s00_axi.rvalid  = r_rvalid;
    assign s00_axi.rresp   = r_rresp;
    assign s00_axi.rdata   = r_rdata;
    assign cfg_regs        = r_cfg;
    assign cfg_wr_stb      = r_wr_stb;

    // Byte-lane bits are ignored: every access is a full word.
    assign w_unused_addr_bits = ^{s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

    assign w_aw_hs   = s00_axi.awvalid & ~r_aw_held;
    assign w_w_hs    = s00_axi.wvalid & ~r_w_held;
    assign w_aw_av   = r_aw_held | w_aw_hs;
    assign w_w_av    = r_w_held | w_w_hs;
    assign w_b_free  = ~r_bvalid | s00_axi.bready;
    assign w_commit  = w_aw_av & w_w_av & w_b_free;
    assign w_wr_addr = r_aw_held ? r_awaddr : s00_axi.awaddr;
    assign w_wr_data = r_w_held ? r_wdata : s00_axi.wdata;
    assign w_wr_idx  = w_wr_addr[AW-1:2];
    assign w_wr_ok   = (w_wr_idx >= IDX_W'(2)) && (w_wr_idx < NUM_IDX);

    always_comb begin
        w_wr_hot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_hot[i] = w_wr_ok && (w_wr_idx == IDX_W'(i));
        end
    end

    assign w_arready = ~r_rvalid | s00_axi.rready;
    assign w_ar_hs   = s00_axi.arvalid & w_arready;
    assign w_rd_idx  = s00_axi.araddr[AW-1:2];

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = SLVERR;
        if (w_rd_idx == IDX_W'(0)) begin
            w_rd_data = ID_VALUE;
            w_rd_resp = OKAY;
        end else if (w_rd_idx == IDX_W'(1)) begin
            w_rd_data = status_in;
            w_rd_resp = OKAY;
        end else begin
            for (int i = 2; i < NUM_REGS; i++) begin
                if (w_rd_idx == IDX_W'(i)) begin
                    w_rd_data = r_cfg[(i-2)*DW +: DW];
                    w_rd_resp = OKAY;
                end
            end
        end
    end

    // Write path: a channel that arrives without its partner, or while B is still
    // occupied, is parked in its holding register until the commit edge.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
            r_wr_stb  <= '0;
            r_cfg     <= {(NUM_REGS-2){RW_RESET}};
        end else begin
            r_wr_stb <= '0;
            if (w_commit) begin
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_ok ? OKAY : SLVERR;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_wr_stb  <= w_wr_hot;
                for (int i = 2; i < NUM_REGS; i++) begin
                    if (w_wr_hot[i]) begin
                        r_cfg[(i-2)*DW +: DW] <= w_wr_data;
                    end
                end
            end else begin
                if (s00_axi.bready) begin
                    r_bvalid <= 1'b0;
                end
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= s00_axi.awaddr;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= s00_axi.wdata;
                end
            end
        end
    end

    // Read path samples the registers before any same-edge write lands, so it sees old data.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_rvalid <= 1'b0;
            r_rresp  <= OKAY;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_resp;
            r_rdata  <= w_rd_data;
        end else if (s00_axi.rready) begin
            r_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tmr_cfg_regfile.sv
// Directed plus randomized check of tmr_cfg_regfile against an array-based register model.
module tb_tmr_cfg_regfile;
    localparam int          DW = 32;
    localparam int          AW = 32;
    localparam int          NR = 8;
    localparam logic [31:0] ID = 32'h544D5230;
    localparam int          CW = (NR-2)*DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] status_in;
    logic [CW-1:0] cfg_regs;
    logic [NR-1:0] cfg_wr_stb;

    tmr_cfg_regfile_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    tmr_cfg_regfile #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NR),
        .ID_VALUE(ID),
        .RW_RESET(32'h0)
    ) dut (
        .axi_aclk(clk),
        .axi_resetn(rst_n),
        .s00_axi(bus),
        .status_in(status_in),
        .cfg_regs(cfg_regs),
        .cfg_wr_stb(cfg_wr_stb)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_regs [NR];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
    endfunction

    function automatic logic [1:0] m_wr(input logic [31:0] addr, input logic [31:0] data,
                                        output logic [NR-1:0] stb);
        int unsigned idx = addr >> 2;
        stb = '0;
        if (idx >= 2 && idx < NR) begin
            m_regs[idx] = data;
            stb[idx] = 1'b1;
            return 2'b00;
        end
        return 2'b10;
    endfunction

    function automatic logic [1:0] m_rd(input logic [31:0] addr, output logic [31:0] data);
        int unsigned idx = addr >> 2;
        data = 32'h0;
        if (idx == 0) data = ID;
        else if (idx == 1) data = status_in;
        else if (idx < NR) data = m_regs[idx];
        else return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [CW-1:0] m_cfg();
        logic [CW-1:0] v;
        for (int i = 2; i < NR; i++) v[(i-2)*DW +: DW] = m_regs[i];
        return v;
    endfunction

    // Called at a falling edge; AW and W are presented together and B is taken immediately.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp,
                      output logic [NR-1:0] stb, output logic lat_ok);
        int   n = 0;
        logic a, w;
        bus.awaddr = addr; bus.wdata = data;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        while ((bus.awvalid || bus.wvalid) && n < 20) begin
            a = bus.awvalid && bus.awready;
            w = bus.wvalid && bus.wready;
            @(negedge clk);
            if (a) bus.awvalid = 1'b0;
            if (w) bus.wvalid = 1'b0;
            n++;
        end
        lat_ok = bus.bvalid && !bus.awvalid && !bus.wvalid;
        resp = bus.bresp;
        stb = cfg_wr_stb;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                      output logic lat_ok);
        int   n = 0;
        logic a;
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
        while (bus.arvalid && n < 20) begin
            a = bus.arready;
            @(negedge clk);
            if (a) bus.arvalid = 1'b0;
            n++;
        end
        lat_ok = bus.rvalid && !bus.arvalid;
        data = bus.rdata;
        resp = bus.rresp;
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    logic [31:0]   rdat, exp_d, addr, data, old_v;
    logic [1:0]    resp, exp_r;
    logic [NR-1:0] stb, exp_stb;
    logic          lat;
    logic [1:0]    b1_resp;

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        status_in = 32'h1234_5678;
        m_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        check("rst_rdata", bus.rdata, 0);
        check("rst_cfg", cfg_regs, m_cfg());
        check("rst_stb", cfg_wr_stb, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ID and status reads
        rd(32'h0, rdat, resp, lat);
        check("id_lat", lat, 1); check("id_data", rdat, ID); check("id_resp", resp, 2'b00);
        rd(32'h4, rdat, resp, lat);
        check("stat_data", rdat, 32'h1234_5678); check("stat_resp", resp, 2'b00);
        status_in = 32'hCAFE_0001;
        rd(32'h7, rdat, resp, lat);
        check("stat_lowbits", rdat, 32'hCAFE_0001);

        // Same-cycle AW+W
        wr(32'h8, 32'hDEADBEEF, resp, stb, lat);
        exp_r = m_wr(32'h8, 32'hDEADBEEF, exp_stb);
        check("w8_lat", lat, 1); check("w8_resp", resp, exp_r); check("w8_stb", stb, exp_stb);
        check("w8_cfg", cfg_regs, m_cfg());
        rd(32'h8, rdat, resp, lat);
        check("r8_data", rdat, 32'hDEADBEEF);

        // W leads AW by 3 cycles
        bus.wdata = 32'h5; bus.wvalid = 1'b1; bus.bready = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        check("wlead_wready_low", bus.wready, 0);
        @(negedge clk);
        check("wlead_no_b", bus.bvalid, 0);
        @(negedge clk);
        bus.awaddr = 32'hC; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        exp_r = m_wr(32'hC, 32'h5, exp_stb);
        check("wlead_bvalid", bus.bvalid, 1); check("wlead_resp", bus.bresp, exp_r);
        check("wlead_stb", cfg_wr_stb, exp_stb); check("wlead_ready", bus.wready, 1);
        @(negedge clk);
        bus.bready = 1'b0;
        check("wlead_cfg", cfg_regs, m_cfg());

        // Error writes and reads
        wr(32'h0, 32'h1111_1111, resp, stb, lat);
        check("err0_resp", resp, 2'b10); check("err0_stb", stb, 0);
        wr(32'h4, 32'h2222_2222, resp, stb, lat);
        check("err4_resp", resp, 2'b10); check("err4_stb", stb, 0);
        wr(32'h20, 32'h3333_3333, resp, stb, lat);
        check("err20_resp", resp, 2'b10); check("err20_stb", stb, 0);
        check("err_cfg", cfg_regs, m_cfg());
        rd(32'h0, rdat, resp, lat);
        check("err_id", rdat, ID);
        rd(32'h20, rdat, resp, lat);
        check("rd20_resp", resp, 2'b10); check("rd20_data", rdat, 0);

        // B back-pressure with a second write queued
        bus.bready = 1'b0;
        bus.awaddr = 32'h10; bus.wdata = 32'hA5A5_0001; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge clk);
        exp_r = m_wr(32'h10, 32'hA5A5_0001, exp_stb);
        b1_resp = exp_r;
        check("bp_b1_valid", bus.bvalid, 1); check("bp_b1_stb", cfg_wr_stb, exp_stb);
        bus.awaddr = 32'h14; bus.wdata = 32'h5A5A_0002;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("bp_readies_low", {bus.awready, bus.wready}, 2'b00);
        repeat (4) begin
            @(negedge clk);
            check("bp_b1_hold", {bus.bvalid, bus.bresp, cfg_wr_stb}, {1'b1, b1_resp, {NR{1'b0}}});
        end
        check("bp_cfg_b1", cfg_regs, m_cfg());
        bus.bready = 1'b1;
        @(negedge clk);
        exp_r = m_wr(32'h14, 32'h5A5A_0002, exp_stb);
        check("bp_b2_valid", bus.bvalid, 1); check("bp_b2_resp", bus.bresp, exp_r);
        check("bp_b2_stb", cfg_wr_stb, exp_stb); check("bp_b2_cfg", cfg_regs, m_cfg());
        check("bp_readies_back", {bus.awready, bus.wready}, 2'b11);
        @(negedge clk);
        check("bp_b2_done", bus.bvalid, 0);
        bus.bready = 1'b0;

        // Same-edge read and write of one register
        old_v = m_regs[4];
        bus.awaddr = 32'h10; bus.wdata = 32'h0BAD_F00D; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 32'h10; bus.arvalid = 1'b1; bus.bready = 1'b1; bus.rready = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        exp_r = m_wr(32'h10, 32'h0BAD_F00D, exp_stb);
        check("rw_old_data", bus.rdata, old_v); check("rw_rvalid", bus.rvalid, 1);
        check("rw_bvalid", bus.bvalid, 1); check("rw_cfg_new", cfg_regs, m_cfg());
        @(negedge clk);
        bus.bready = 1'b0; bus.rready = 1'b0;

        // Randomized traffic against the model
        for (int k = 0; k < 60; k++) begin
            addr = ($urandom_range(0, NR + 1) << 2) | $urandom_range(0, 3);
            data = $urandom;
            status_in = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                wr(addr, data, resp, stb, lat);
                exp_r = m_wr(addr, data, exp_stb);
                check("rnd_w_lat", lat, 1); check("rnd_w_resp", resp, exp_r);
                check("rnd_w_stb", stb, exp_stb); check("rnd_w_cfg", cfg_regs, m_cfg());
            end else begin
                exp_r = m_rd(addr, exp_d);
                rd(addr, rdat, resp, lat);
                check("rnd_r_lat", lat, 1); check("rnd_r_resp", resp, exp_r);
                check("rnd_r_data", rdat, exp_d);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Async reset with AW held and no W
        bus.awaddr = 32'h18; bus.awvalid = 1'b1; bus.bready = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        check("mid_aw_held", bus.awready, 0);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check("mid_bvalid", bus.bvalid, 0);
        check("mid_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        check("mid_cfg", cfg_regs, m_cfg());
        @(negedge clk);
        rst_n = 1'b1;
        bus.wdata = 32'h77; bus.wvalid = 1'b1;
        @(negedge clk);
        bus.wvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_no_stale_b", bus.bvalid, 0);
        bus.awaddr = 32'h18; bus.awvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0;
        exp_r = m_wr(32'h18, 32'h77, exp_stb);
        check("post_b", {bus.bvalid, bus.bresp}, {1'b1, exp_r});
        check("post_stb", cfg_wr_stb, exp_stb);
        @(negedge clk);
        bus.bready = 1'b0;
        check("post_cfg", cfg_regs, m_cfg());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
